// File: rtl/reg_dump.sv
// ============================================================================
// reg_dump
// ----------------------------------------------------------------------------
// Sequential debug reader for the CPU register file. A start pulse walks an
// inclusive, wrap-around range of register indices. For each index it drives
// rd_idx to a spare read port, captures the combinational read data and
// streams the (index, value) pair out over a valid/ready handshake. It never
// writes the register file.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   begin a dump (only honoured in IDLE)
//   first_idx  in   first index of the range (latched on start)
//   last_idx   in   last index of the range (latched on start)
//   rd_idx     out  read address to the register file (registered)
//   rd_val     in   combinational read data for rd_idx
//   out_valid  out  out_idx/out_data hold a word
//   out_ready  in   consumer accepts the word
//   out_idx    out  register index of the current word
//   out_data   out  register value of the current word
//   busy       out  dump in progress (FETCH or SEND)
//   done       out  one-cycle pulse after the last word transfers
// ============================================================================
module reg_dump #(
    parameter int REG_WIDTH      = 16,
    parameter int NUM_REGS_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_REGS_WIDTH-1:0] first_idx,
    input  logic [NUM_REGS_WIDTH-1:0] last_idx,
    output logic [NUM_REGS_WIDTH-1:0] rd_idx,
    input  logic [REG_WIDTH-1:0]      rd_val,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_REGS_WIDTH-1:0] out_idx,
    output logic [REG_WIDTH-1:0]      out_data,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Walk position and the latched end of the range. Only the end needs to
    // be kept: the start of the range seeds cur directly.
    logic [NUM_REGS_WIDTH-1:0] cur_q,  cur_d;
    logic [NUM_REGS_WIDTH-1:0] last_q, last_d;

    // Registered outputs.
    logic [NUM_REGS_WIDTH-1:0] rd_idx_q,   rd_idx_d;
    logic [NUM_REGS_WIDTH-1:0] out_idx_q,  out_idx_d;
    logic [REG_WIDTH-1:0]      out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q,      busy_d;
    logic                      done_q,      done_d;

    logic [NUM_REGS_WIDTH-1:0] cur_inc;
    logic                      at_last;
    logic                      xfer;

    // Natural overflow of the index width gives the mod 2^N wrap for free.
    assign cur_inc = cur_q + NUM_REGS_WIDTH'(1);
    assign at_last = (cur_q == last_q);
    // out_valid_q is high exactly in SEND, so this is the handshake.
    assign xfer    = (state_q == SEND) && out_ready;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            rd_idx_q    <= '0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            rd_idx_q    <= rd_idx_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: each always_comb assigns a default to every target first, so no
    // path through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = FETCH;
            FETCH: state_d = SEND;
            SEND:  if (xfer) state_d = at_last ? DONE : FETCH;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------------
    always_comb begin
        cur_d      = cur_q;
        last_d     = last_q;
        rd_idx_d   = rd_idx_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d    = first_idx;
                    last_d   = last_idx;
                    // Present the address a cycle early so the registered
                    // rd_idx already equals cur throughout FETCH.
                    rd_idx_d = first_idx;
                end
            end
            FETCH: begin
                // Snapshot taken here is what makes already-fetched words
                // immune to later writes to the register file.
                out_data_d = rd_val;
                out_idx_d  = cur_q;
            end
            SEND: begin
                if (xfer && !at_last) begin
                    cur_d    = cur_inc;
                    rd_idx_d = cur_inc;
                end
            end
            DONE: begin
            end
            default: begin
            end
        endcase

        // Flags are registered copies of the state being entered, which
        // keeps every output glitch-free and aligned with the state.
        out_valid_d = (state_d == SEND);
        busy_d      = (state_d == FETCH) || (state_d == SEND);
        done_d      = (state_d == DONE);
    end

    assign rd_idx    = rd_idx_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/reg_dump.md
# reg_dump

Sequential reader for the CPU register file. On a start pulse it walks a range of register indices, drives each index onto a spare register-file read-address port, captures the returned value, and streams (index, value) pairs out over a valid/ready handshake. It sits beside `registers` as a debug and trace path, for example feeding a UART or a test harness, and never writes the register file.

## Interface

Parameters:
- `REG_WIDTH`, default 16: register data width.
- `NUM_REGS_WIDTH`, default 3: index width. The file holds 2^`NUM_REGS_WIDTH` registers.

Ports:
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `start` input, 1 bit: begin a dump. Sampled only in IDLE.
- `first_idx` input, `NUM_REGS_WIDTH` bits: first index to dump. Latched when `start` is accepted.
- `last_idx` input, `NUM_REGS_WIDTH` bits: last index to dump. Latched when `start` is accepted.
- `rd_idx` output, `NUM_REGS_WIDTH` bits: read address driven to the register file.
- `rd_val` input, `REG_WIDTH` bits: combinational read data from the register file for `rd_idx`.
- `out_valid` output, 1 bit: `out_idx`/`out_data` hold a word.
- `out_ready` input, 1 bit: consumer accepts the word.
- `out_idx` output, `NUM_REGS_WIDTH` bits: register index of the current word.
- `out_data` output, `REG_WIDTH` bits: register value of the current word.
- `busy` output, 1 bit: dump in progress.
- `done` output, 1 bit: one-cycle pulse after the last word transfers.

## Operation

- States: IDLE, FETCH, SEND, DONE.
- **IDLE**
  - `start`=1: latch `first_idx`/`last_idx`, set the current index `cur` = `first_idx`, go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH**
  - `rd_idx` = `cur`.
  - At the clock edge, capture `rd_val` into `out_data` and `cur` into `out_idx`, then go to SEND.
- **SEND**
  - `out_valid`=1. Hold in SEND while `out_ready`=0.
  - On `out_valid`&&`out_ready`: if `cur` == latched last, go to DONE; else `cur` = (`cur`+1) mod 2^`NUM_REGS_WIDTH` and go to FETCH.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.
- Range and wrap-around:
  - Word count = ((last − first) mod 2^`NUM_REGS_WIDTH`) + 1.
  - first == last gives 1 word.
  - last < first wraps through the top index to 0. Example: first=6, last=1 with 8 registers gives 6,7,0,1.
  - A full dump is last = first − 1 (mod), which gives 2^`NUM_REGS_WIDTH` words.
- `start` in any state other than IDLE is ignored. The latched range never changes mid-dump.
- Coherence: each value is the register contents as of that word's FETCH cycle. Writes to the file during a dump are visible for indices not yet fetched and invisible for indices already fetched.
- `rd_idx` outside FETCH holds the last driven value. It is 0 after reset.
- `busy` = 1 in FETCH and SEND, 0 in IDLE and DONE.

## Timing

- Reset (`rst`=1 at an edge):
  - State goes to IDLE.
  - `out_valid`=0, `done`=0, `busy`=0, `rd_idx`=0, `out_idx`=0, `out_data`=0.
  - Reset mid-dump aborts the dump with no `done` pulse. The partially held word is dropped.
- Latency:
  - `start` sampled at edge N puts FETCH in cycle N+1.
  - `out_valid` rises in cycle N+2.
- Throughput: 2 cycles per word when `out_ready` stays 1. An n-word dump with no stalls asserts `done` in cycle N+2n+1.
- Handshake:
  - While `out_valid`=1 and `out_ready`=0, `out_idx`/`out_data` are stable.
  - `out_valid` does not drop before the transfer.
  - `out_valid` is 0 in FETCH, so there is a one-cycle bubble between words.
- `start` sampled in the DONE cycle is ignored. A new dump can start from IDLE at the next edge.
- All outputs are registered except `rd_idx`, which may be registered or decoded from state, as long as it equals `cur` throughout FETCH.

## Test plan

- Reset, then drive regs = 0x1000+i for i=0..7. Pulse `start` with first=0, last=7, `out_ready`=1 → 8 words (i, 0x1000+i) in order, out_valid every other cycle, `done` at cycle N+17, `busy` low after.
- Wrap: first=6, last=1 → words with idx 6,7,0,1 and their values, then a single `done` pulse.
- Back-pressure: `out_ready` low 5 cycles on word 2 → `out_valid` held, `out_idx`/`out_data` stable all 5 cycles. No word lost or duplicated.
- Single word and full dump: first=last=3 → one word idx 3, `done` at N+3. first=5, last=4 → 8 words starting at 5.
- Coherence and ignore: write reg 7=0xBEEF while word 2 stalls in SEND (range 0..7) → word 7 reports 0xBEEF. `start` pulses mid-dump have no effect.
- Reset mid-dump during SEND → next cycle `out_valid`=0, `busy`=0, no `done`. A following `start` performs a clean full dump.
